// File: rtl/cb_deserializer_8_if.sv
// Handshake and parallel-frame bundle for the commutator-buffer deserializer.
// The slave side is the deserializer; the master side is whoever drives the serial stream and consumes frames.
interface cb_deserializer_8_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_sof;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] Q0;
    logic [DATA_WIDTH-1:0] Q1;
    logic [DATA_WIDTH-1:0] Q2;
    logic [DATA_WIDTH-1:0] Q3;
    logic [DATA_WIDTH-1:0] Q4;
    logic [DATA_WIDTH-1:0] Q5;
    logic [DATA_WIDTH-1:0] Q6;
    logic [DATA_WIDTH-1:0] Q7;
    logic                  frame_err;

    modport slave (
        input  in_valid, in_data, in_sof, out_ready,
        output in_ready, out_valid, frame_err,
        output Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7
    );

    modport master (
        output in_valid, in_data, in_sof, out_ready,
        input  in_ready, out_valid, frame_err,
        input  Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7
    );
endinterface

// File: rtl/cb_deserializer_8.sv
// Regroups the serial word stream from the 8-deep commutator shift segment into 8-word parallel frames.
// It has a collect bank and an output bank. The 8th word goes straight into Q7, so a frame appears on Q one cycle after that word.
module cb_deserializer_8 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    cb_deserializer_8_if.slave   bus
);
    localparam logic [2:0] LAST_SLOT = 3'd7;

    logic [2:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] c_q [0:7];
    logic [DATA_WIDTH-1:0] c_d [0:7];
    logic [DATA_WIDTH-1:0] q_q [0:7];
    logic [DATA_WIDTH-1:0] q_d [0:7];
    logic                  out_valid_q, out_valid_d;
    logic                  frame_err_q, frame_err_d;

    logic       free;
    logic       in_ready;
    logic       accept;
    logic       complete;
    logic [2:0] idx;

    // Stall only when the 8th word would overwrite a frame that has not been consumed; this path is combinational from out_ready.
    assign free     = !out_valid_q || bus.out_ready;
    assign in_ready = (cnt_q != LAST_SLOT) || free;
    assign accept   = bus.in_valid && in_ready;
    assign idx      = bus.in_sof ? 3'd0 : cnt_q;
    assign complete = accept && (idx == LAST_SLOT);

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path leaves a latch.
        cnt_d       = cnt_q;
        c_d         = c_q;
        q_d         = q_q;
        out_valid_d = out_valid_q;
        frame_err_d = 1'b0;

        if (accept) begin
            c_d[idx]    = bus.in_data;
            cnt_d       = idx + 3'd1;
            frame_err_d = bus.in_sof && (cnt_q != 3'd0);
            if (complete) begin
                for (int i = 0; i < 7; i++) q_d[i] = c_q[i];
                q_d[7]      = bus.in_data;
                out_valid_d = 1'b1;
            end
        end

        if (!complete && out_valid_q && bus.out_ready) out_valid_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the banks are reset as well, because after reset Q must read zero and not hold stale samples.
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                c_q[i] <= '0;
                q_q[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every register samples the values from before this edge.
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            for (int i = 0; i < 8; i++) begin
                c_q[i] <= c_d[i];
                q_q[i] <= q_d[i];
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.Q0        = q_q[0];
    assign bus.Q1        = q_q[1];
    assign bus.Q2        = q_q[2];
    assign bus.Q3        = q_q[3];
    assign bus.Q4        = q_q[4];
    assign bus.Q5        = q_q[5];
    assign bus.Q6        = q_q[6];
    assign bus.Q7        = q_q[7];
endmodule

// File: tb/tb_cb_deserializer_8.sv
// Self-checking bench for cb_deserializer_8. It uses a queue-based frame model, a stimulus table,
// hand-written reset and streaming sequences, and a random run checked by a scoreboard.
module tb_cb_deserializer_8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cb_deserializer_8_if #(.DATA_WIDTH(DW)) bus ();

    cb_deserializer_8 #(.DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [DW-1:0] w [8];
    } frame_t;

    typedef struct {
        bit            v, s, r;
        logic [DW-1:0] d;
        bit            e_rdy, e_ov, e_err;
        logic [DW-1:0] e_q0, e_q7;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the words of the current partial frame, plus the frame shown on the output.
    logic [DW-1:0] m_partial [$];
    logic [DW-1:0] m_q [8];
    bit            m_ov, m_err, m_acc;

    frame_t        consumed [$];
    logic [DW-1:0] sent [$];
    vec_t          vecs [$];
    bit            last_ready;

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] dut_q(input int i);
        case (i)
            0: return bus.Q0;
            1: return bus.Q1;
            2: return bus.Q2;
            3: return bus.Q3;
            4: return bus.Q4;
            5: return bus.Q5;
            6: return bus.Q6;
            default: return bus.Q7;
        endcase
    endfunction

    function automatic void model_reset();
        m_partial.delete();
        for (int i = 0; i < 8; i++) m_q[i] = '0;
        m_ov  = 1'b0;
        m_err = 1'b0;
    endfunction

    function automatic bit model_ready(input bit r);
        return !(m_partial.size() == 7 && m_ov && !r);
    endfunction

    function automatic void model_step(input bit v, input bit s, input bit r, input logic [DW-1:0] d);
        bit done = 1'b0;
        m_acc = v && model_ready(r);
        m_err = 1'b0;
        if (m_acc) begin
            if (s) begin
                m_err = (m_partial.size() != 0);
                m_partial.delete();
            end
            m_partial.push_back(d);
            if (m_partial.size() == 8) begin
                for (int i = 0; i < 8; i++) m_q[i] = m_partial[i];
                m_partial.delete();
                m_ov = 1'b1;
                done = 1'b1;
            end
        end
        if (!done && m_ov && r) m_ov = 1'b0;
    endfunction

    task automatic check_outputs();
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_ov});
        check("frame_err", {31'd0, bus.frame_err}, {31'd0, m_err});
        for (int i = 0; i < 8; i++) check($sformatf("Q%0d", i), dut_q(i), m_q[i]);
    endtask

    // One clock cycle. The task starts at a falling edge, drives the inputs, checks in_ready,
    // lets the rising edge pass, then checks the registered outputs at the next falling edge.
    task automatic drive(input bit v, input bit s, input bit r, input logic [DW-1:0] d);
        frame_t f;
        bus.in_valid  = v;
        bus.in_sof    = s;
        bus.in_data   = d;
        bus.out_ready = r;
        #1;
        last_ready = bus.in_ready;
        check("in_ready", {31'd0, bus.in_ready}, {31'd0, model_ready(r)});
        if (bus.out_valid && r) begin
            for (int i = 0; i < 8; i++) f.w[i] = dut_q(i);
            consumed.push_back(f);
        end
        @(posedge clk);
        model_step(v, s, r, d);
        @(negedge clk);
        check_outputs();
    endtask

    function automatic void add(input bit v, input bit s, input bit r, input logic [DW-1:0] d,
                                input bit e_rdy, input bit e_ov, input bit e_err,
                                input logic [DW-1:0] e_q0, input logic [DW-1:0] e_q7);
        vec_t x;
        x.v = v; x.s = s; x.r = r; x.d = d;
        x.e_rdy = e_rdy; x.e_ov = e_ov; x.e_err = e_err; x.e_q0 = e_q0; x.e_q7 = e_q7;
        vecs.push_back(x);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int words, cycles, pulses;

        // Table: frame A under backpressure, B stalled then released, resync, sof in slot 7, simultaneous consume and complete.
        for (int i = 0; i < 8; i++)
            add(1, 0, 0, 32'hA0 + i, 1, i == 7, 0, (i == 7) ? 32'hA0 : 32'h0, (i == 7) ? 32'hA7 : 32'h0);
        for (int i = 0; i < 7; i++) add(1, 0, 0, 32'hB0 + i, 1, 1, 0, 32'hA0, 32'hA7);
        add(1, 0, 0, 32'hB7, 0, 1, 0, 32'hA0, 32'hA7);
        add(1, 0, 0, 32'hB7, 0, 1, 0, 32'hA0, 32'hA7);
        add(1, 0, 1, 32'hB7, 1, 1, 0, 32'hB0, 32'hB7);
        for (int i = 0; i < 3; i++) add(1, 0, 1, 32'hC0 + i, 1, 0, 0, 32'hB0, 32'hB7);
        add(1, 1, 1, 32'hAA, 1, 0, 1, 32'hB0, 32'hB7);
        for (int i = 1; i < 8; i++)
            add(1, 0, 0, 32'hD0 + i, 1, i == 7, 0, (i == 7) ? 32'hAA : 32'hB0, (i == 7) ? 32'hD7 : 32'hB7);
        for (int i = 0; i < 7; i++) add(1, 0, 1, 32'hE0 + i, 1, 0, 0, 32'hAA, 32'hD7);
        add(1, 1, 1, 32'hF0, 1, 0, 1, 32'hAA, 32'hD7);
        add(0, 0, 0, 32'h0, 1, 0, 0, 32'hAA, 32'hD7);
        for (int i = 1; i < 8; i++)
            add(1, 0, 0, 32'hF0 + i, 1, i == 7, 0, (i == 7) ? 32'hF0 : 32'hAA, (i == 7) ? 32'hF7 : 32'hD7);
        for (int i = 0; i < 7; i++) add(1, 0, 0, 32'h50 + i, 1, 1, 0, 32'hF0, 32'hF7);
        add(1, 0, 1, 32'h57, 1, 1, 0, 32'h50, 32'h57);
        add(0, 0, 1, 32'h0, 1, 0, 0, 32'h50, 32'h57);

        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outputs();

        foreach (vecs[k]) begin
            drive(vecs[k].v, vecs[k].s, vecs[k].r, vecs[k].d);
            check("tbl_in_ready", {31'd0, last_ready}, {31'd0, vecs[k].e_rdy});
            check("tbl_out_valid", {31'd0, bus.out_valid}, {31'd0, vecs[k].e_ov});
            check("tbl_frame_err", {31'd0, bus.frame_err}, {31'd0, vecs[k].e_err});
            check("tbl_Q0", bus.Q0, vecs[k].e_q0);
            check("tbl_Q7", bus.Q7, vecs[k].e_q7);
        end

        // T1: assert reset in the middle of a frame (cnt=5) while an unconsumed frame is held on the output.
        for (int i = 0; i < 13; i++) drive(1, 0, 0, 32'h300 + i);
        check("t1_pre_ov", {31'd0, bus.out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t1_rst_ov", {31'd0, bus.out_valid}, 32'd0);
        check("t1_rst_err", {31'd0, bus.frame_err}, 32'd0);
        check("t1_rst_ready", {31'd0, bus.in_ready}, 32'd1);
        for (int i = 0; i < 8; i++) check($sformatf("t1_rst_Q%0d", i), dut_q(i), 32'h0);
        @(negedge clk);
        check("t1_rst_hold_ov", {31'd0, bus.out_valid}, 32'd0);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) drive(1, 0, 1, 32'h10 + i);
        check("t1_ov", {31'd0, bus.out_valid}, 32'd1);
        for (int i = 0; i < 8; i++) check($sformatf("t1_Q%0d", i), dut_q(i), 32'h10 + i);

        // T2: 32 back-to-back words with the consumer always ready.
        drive(0, 0, 1, 32'h0);
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            drive(1, 0, 1, i);
            if (bus.out_valid) pulses++;
            if (i % 8 == 7) begin
                check("t2_Q0", bus.Q0, i - 7);
                check("t2_Q7", bus.Q7, i);
            end
        end
        check("t2_pulses", pulses, 32'd4);

        // T6: random valid and ready. The scoreboard checks that consumed frames match the words sent, in order.
        drive(0, 0, 1, 32'h0);
        consumed.delete();
        sent.delete();
        words  = 0;
        cycles = 0;
        while (words < 64 && cycles < 2000) begin
            logic [DW-1:0] d;
            bit v, r;
            v = ($urandom % 2) == 1;
            r = ($urandom % 2) == 1;
            d = $urandom;
            drive(v, 0, r, d);
            if (m_acc) begin
                sent.push_back(d);
                words++;
            end
            cycles++;
        end
        check("t6_words", words, 32'd64);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 32'h0);
        check("t6_frames", consumed.size(), 32'd8);
        foreach (consumed[f]) begin
            for (int i = 0; i < 8; i++) begin
                if (f * 8 + i < sent.size())
                    check($sformatf("t6_f%0d_w%0d", f, i), consumed[f].w[i], sent[f * 8 + i]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
